// File: rtl/coeff_bank_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coeff_bank_ctrl : double-buffered biquad coefficient bank; loads a shadow   |
// | set from the SPI loader and commits it at a stereo frame boundary.          |
// | Optional build macro: COEFF_CHECKSUM_EN (trailing checksum word check).     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module coeff_bank_ctrl #(
    parameter int NCOEFFS     = 20,
    parameter int COEFF_NBITS = 32,
    parameter int ADDR_BITS   = 5,
    parameter int WS_TIMEOUT  = 65535
) (
    input  logic                             i_clk_sys,
    input  logic                             i_rstn,
    input  logic                             i_coeffs_rdy,
    output logic [ADDR_BITS-1:0]             o_coeff_addr,
    input  logic [COEFF_NBITS-1:0]           i_coeff_data,
    input  logic                             i_ws,
    output logic [NCOEFFS*COEFF_NBITS-1:0]   o_coeff_flat,
    output logic                             o_bank_swap,
    output logic                             o_busy,
    output logic                             o_load_err
);

    localparam int TMO_BITS = $clog2(WS_TIMEOUT + 1);
    localparam logic [ADDR_BITS-1:0] c_ncoeffs  = ADDR_BITS'(NCOEFFS);
    localparam logic [TMO_BITS-1:0]  c_tmo_last = TMO_BITS'(WS_TIMEOUT - 1);
`ifdef COEFF_CHECKSUM_EN
    localparam logic [ADDR_BITS-1:0] c_last_idx = ADDR_BITS'(NCOEFFS);
`else
    localparam logic [ADDR_BITS-1:0] c_last_idx = ADDR_BITS'(NCOEFFS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_WAIT  = 3'd4,
        S_SWAP  = 3'd5
    } state_t;

    state_t                          r_state;
    logic [2:0]                      r_rdy_sync;
    logic [2:0]                      r_ws_sync;
    logic [ADDR_BITS-1:0]            r_coeff_addr;
    logic [COEFF_NBITS-1:0]          r_shadow [0:NCOEFFS-1];
    logic [NCOEFFS*COEFF_NBITS-1:0]  r_active;
    logic [TMO_BITS-1:0]             r_tmo;
    logic                            r_pending;
    logic                            r_busy;
    logic                            r_swap;
`ifdef COEFF_CHECKSUM_EN
    logic [COEFF_NBITS-1:0]          r_acc;
    logic [COEFF_NBITS-1:0]          r_csum;
    logic                            r_err;
`endif

    logic w_trig;
    logic w_ws_fall;

    // Bit 1 is the synchronised level, bit 2 its previous value.
    assign w_trig    =  r_rdy_sync[1] & ~r_rdy_sync[2];
    assign w_ws_fall = ~r_ws_sync[1]  &  r_ws_sync[2];

    always_ff @(posedge i_clk_sys or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_rdy_sync   <= '0;
            r_ws_sync    <= '0;
            r_coeff_addr <= '0;
            r_active     <= '0;
            r_tmo        <= '0;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_swap       <= 1'b0;
            for (int k = 0; k < NCOEFFS; k++) begin
                r_shadow[k] <= '0;
            end
`ifdef COEFF_CHECKSUM_EN
            r_acc        <= '0;
            r_csum       <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_rdy_sync <= {r_rdy_sync[1:0], i_coeffs_rdy};
            r_ws_sync  <= {r_ws_sync[1:0], i_ws};
            r_swap     <= 1'b0;

            // Only one trigger is remembered while a load is in flight.
            if (w_trig && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_coeff_addr <= '0;
                    if (w_trig) begin
                        r_state <= S_ADDR;
                        r_busy  <= 1'b1;
`ifdef COEFF_CHECKSUM_EN
                        r_acc   <= '0;
`endif
                    end
                end

                S_ADDR: begin
                    r_state <= S_DATA;
                end

                S_DATA: begin
                    if (r_coeff_addr < c_ncoeffs) begin
                        r_shadow[r_coeff_addr] <= i_coeff_data;
                    end
`ifdef COEFF_CHECKSUM_EN
                    if (r_coeff_addr == c_ncoeffs) begin
                        r_csum <= i_coeff_data;
                    end else begin
                        r_acc <= r_acc + i_coeff_data;
                    end
`endif
                    if (r_coeff_addr == c_last_idx) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_coeff_addr <= r_coeff_addr + 1'b1;
                        r_state      <= S_ADDR;
                    end
                end

                S_CHECK: begin
`ifdef COEFF_CHECKSUM_EN
                    if (r_acc != r_csum) begin
                        // Bad set: drop the shadow contents, keep the active bank.
                        r_err        <= 1'b1;
                        r_coeff_addr <= '0;
                        r_acc        <= '0;
                        if (r_pending || w_trig) begin
                            r_state   <= S_ADDR;
                            r_busy    <= 1'b1;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_WAIT;
                        r_tmo   <= '0;
                    end
`else
                    r_state <= S_WAIT;
                    r_tmo   <= '0;
`endif
                end

                S_WAIT: begin
                    if (w_ws_fall || (r_tmo == c_tmo_last)) begin
                        for (int k = 0; k < NCOEFFS; k++) begin
                            r_active[k*COEFF_NBITS +: COEFF_NBITS] <= r_shadow[k];
                        end
                        r_swap  <= 1'b1;
                        r_state <= S_SWAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_SWAP: begin
`ifdef COEFF_CHECKSUM_EN
                    r_err        <= 1'b0;
                    r_acc        <= '0;
`endif
                    r_coeff_addr <= '0;
                    if (r_pending || w_trig) begin
                        r_state   <= S_ADDR;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_coeff_addr = r_coeff_addr;
    assign o_coeff_flat = r_active;
    assign o_bank_swap  = r_swap;
    assign o_busy       = r_busy;
`ifdef COEFF_CHECKSUM_EN
    assign o_load_err   = r_err;
`else
    assign o_load_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/coeff_bank_ctrl.md
# coeff_bank_ctrl

Double-buffered biquad coefficient controller between the SPI coefficient loader (`load_coeffs`) and `audiosystem`. On a "coefficients ready" pulse from the loader it reads the full coefficient set into a shadow bank. When checksum checking is compiled in, it also validates the set. It then commits the shadow bank to the active bank only at a stereo frame boundary (falling edge of word select), so the crossover filters never run a sample with a half-updated coefficient set.

## Interface
- `NCOEFFS`, 20: coefficients per set (LP0, LP1, HP0, HP1 × b0, b1, b2, a1, a2).
- `COEFF_NBITS`, 32: coefficient width, signed two's complement.
- `ADDR_BITS`, 5: loader address width.
- `WS_TIMEOUT`, 65535: `i_clk_sys` cycles to wait for a frame boundary before committing anyway.

Ports:
- `i_clk_sys` in 1: system clock, 24 MHz.
- `i_rstn` in 1: asynchronous active-low reset.
- `i_coeffs_rdy` in 1: loader "set ready" level/pulse, asynchronous to `i_clk_sys`; 2-FF synchronised internally.
- `o_coeff_addr` out `ADDR_BITS`: loader read address, registered.
- `i_coeff_data` in `COEFF_NBITS`: loader read data, valid one full cycle after `o_coeff_addr` changes.
- `i_ws` in 1: I2S word select, audio clock domain; 2-FF synchronised internally.
- `o_coeff_flat` out `NCOEFFS*COEFF_NBITS`: active bank; coefficient k occupies bits [k*W +: W].
- `o_bank_swap` out 1: one-cycle pulse in the cycle the active bank updates.
- `o_busy` out 1: high from trigger detection until commit or abort.
- `o_load_err` out 1: sticky checksum error flag.

## Operation
- Trigger: the synchronised `i_coeffs_rdy` history equals 2'b01, i.e. a rising edge.
- States: IDLE, ADDR, DATA, CHECK, WAIT_FRAME, SWAP.
- **IDLE:** `o_coeff_addr` = 0 and the word counter = 0. On trigger go to ADDR, set `o_busy`, and clear the checksum accumulator.
- **ADDR:** one wait cycle, then go to DATA.
- **DATA:** write `shadow[addr]` with `i_coeff_data` and add it to the accumulator (mod 2^W).
  - If addr equals the last word index, go to CHECK.
  - Otherwise increment `o_coeff_addr` and go to ADDR.
  - The last word index is `NCOEFFS-1`, or `NCOEFFS` with the checksum feature compiled in.
- **CHECK:** without the feature, go straight to WAIT_FRAME. With the feature, see Configuration.
- **WAIT_FRAME:** wait for a falling edge of synchronised `i_ws` (left-channel frame start), or for the timeout counter to reach `WS_TIMEOUT`; then go to SWAP.
- **SWAP:** active bank takes shadow, pulse `o_bank_swap`, clear `o_load_err`, drop `o_busy`, go to IDLE.
- Trigger while busy: latch a pending flag. On the exit from SWAP or abort, go directly to ADDR instead of IDLE and clear the pending flag. Only one trigger is queued; extra triggers are dropped.
- The active bank is never written except in SWAP. The shadow bank is never read by the datapath.
- Reset (at any time, including mid-load):
  - state = IDLE.
  - Both banks, `o_coeff_addr`, `o_coeff_flat`, `o_bank_swap`, `o_busy`, `o_load_err`, pending flag, synchronisers and timeout counter all = 0.

## Timing
- Trigger detected 2–3 cycles after the rising edge of `i_coeffs_rdy`.
- Load takes 2 cycles per word: 40 cycles, or 42 with the checksum, from the first ADDR to the last DATA. CHECK takes 1 cycle.
- Frame-boundary detection lags the `i_ws` fall by 2–3 cycles. SWAP is 1 cycle after detection.
- `o_coeff_flat` and `o_bank_swap` change on the same clock edge.
- The timeout counter runs only in WAIT_FRAME and resets on entry.
- Trigger and `i_ws` edge in the same cycle: both are honoured. The trigger is queued if a swap is pending.

## Configuration
- Macro: `COEFF_CHECKSUM_EN`.
- **Defined:**
  - The loader supplies word `NCOEFFS` as a checksum equal to the sum of words 0..`NCOEFFS-1` mod 2^W. The checksum word is not added to the accumulator.
  - In CHECK, a mismatch sets `o_load_err`, discards the shadow bank (no swap, active bank unchanged), drops `o_busy` and goes to IDLE. A match goes to WAIT_FRAME.
- **Undefined:** `NCOEFFS` words are read, CHECK passes unconditionally, and `o_load_err` is tied 0.

## Test plan
- **Reset values:** assert `i_rstn`=0 mid-load (addr=7) → all outputs 0 immediately. After release, state is IDLE and `o_coeff_flat` is 0.
- **Basic load:** loader memory k → 0x1000+k, one `i_coeffs_rdy` pulse, `i_ws` toggling at 48 kHz → 20 reads of addr 0..19 at 2-cycle spacing. A single `o_bank_swap` occurs 2–3 cycles after the next `i_ws` fall, and then `o_coeff_flat` word 19 = 0x1013.
- **No partial update:** sample `o_coeff_flat` every cycle during a load over an existing set of all 0x5 → it is all-0x5 until the swap edge, then all-new.
- **Timeout:** `i_ws` held at 1 → swap occurs exactly `WS_TIMEOUT` cycles after entering WAIT_FRAME.
- **Queued trigger:** a second `i_coeffs_rdy` pulse at addr 10 → after the first swap a second load starts directly, giving exactly 2 swaps. A third pulse in the same load is dropped.
- **Checksum (`COEFF_CHECKSUM_EN`):** word 20 = correct sum + 1 → `o_load_err`=1, no swap, active bank unchanged. The next load with the correct sum → swap and `o_load_err`=0.
